gbc_cart_mem_arbiter: RTL and testbench

GBC_CART_MEM_ARBITER -- requirements
Module: gbc_cart_mem_arbiter

---
 rtl/gbc_mem_pkg.sv | 44 ++++
 rtl/gbc_arb_pick.sv | 27 ++
 rtl/gbc_cart_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_gbc_cart_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbc_mem_pkg.sv
// Shared types and constants for the cartridge memory arbiter: grant and
// FSM encodings, the backing-memory request payload and the CRAM base default.
package gbc_mem_pkg;

  localparam int unsigned ROM_AW = 23;
  localparam int unsigned RAM_AW = 17;
  localparam int unsigned MEM_AW = 24;
  localparam int unsigned DW     = 8;
  localparam int unsigned AGE_W  = 2;
  localparam int unsigned TMO_W  = 8;

  localparam logic [MEM_AW-1:0] CRAM_BASE_DEFAULT = 24'h800000;
  localparam logic [AGE_W-1:0]  AGE_MAX           = '1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ROM  = 2'd1,
    GNT_CRAM = 2'd2,
    GNT_SAV  = 2'd3
  } grant_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic              we;
    logic [DW-1:0]     dat;
  } mem_req_t;

  // Per-requester bit vector, bit 0 = ROM, bit 1 = CRAM, bit 2 = SAV.
  function automatic logic [2:0] gnt_onehot(input grant_e g);
    case (g)
      GNT_ROM:  return 3'b001;
      GNT_CRAM: return 3'b010;
      GNT_SAV:  return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/gbc_arb_pick.sv
// Combinational grant selection: ROM/CRAM round-robin on a last-grant bit,
// SAV only when both are idle or once it has aged out.
module gbc_arb_pick
  import gbc_mem_pkg::*;
(
  input  logic             rom_stb_i,
  input  logic             cram_stb_i,
  input  logic             sav_stb_i,
  input  logic             last_cram_i,
  input  logic [AGE_W-1:0] age_i,
  output grant_e           gnt_c_o
);

  always_comb begin
    gnt_c_o = GNT_NONE;
    if (sav_stb_i && ((!rom_stb_i && !cram_stb_i) || (age_i == AGE_MAX))) begin
      gnt_c_o = GNT_SAV;
    end else if (rom_stb_i && cram_stb_i) begin
      gnt_c_o = last_cram_i ? GNT_ROM : GNT_CRAM;
    end else if (rom_stb_i) begin
      gnt_c_o = GNT_ROM;
    end else if (cram_stb_i) begin
      gnt_c_o = GNT_CRAM;
    end
  end

endmodule

// File: rtl/gbc_cart_mem_arbiter.sv
// Arbitrates ROM, cartridge-RAM and save-RAM requesters onto one pipelined
// Wishbone backing memory. Define GBC_ARB_TIMEOUT_EN for the WAIT watchdog.
module gbc_cart_mem_arbiter
  import gbc_mem_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [MEM_AW-1:0] CRAM_BASE      = CRAM_BASE_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rom_stb_i,
  input  logic              cram_stb_i,
  input  logic              sav_stb_i,
  input  logic              cram_we_i,
  input  logic              sav_we_i,
  input  logic [ROM_AW-1:0] rom_addr_i,
  input  logic [RAM_AW-1:0] cram_addr_i,
  input  logic [RAM_AW-1:0] sav_addr_i,
  input  logic [DW-1:0]     cram_dat_i,
  input  logic [DW-1:0]     sav_dat_i,
  output logic [DW-1:0]     rom_dat_o,
  output logic [DW-1:0]     cram_dat_o,
  output logic [DW-1:0]     sav_dat_o,
  output logic              rom_ack_o,
  output logic              cram_ack_o,
  output logic              sav_ack_o,
  output logic              rom_err_o,
  output logic              cram_err_o,
  output logic              sav_err_o,
  output logic              rom_stall_o,
  output logic              cram_stall_o,
  output logic              sav_stall_o,
  output logic              mem_cyc_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DW-1:0]     mem_dat_o,
  input  logic [DW-1:0]     mem_dat_i,
  input  logic              mem_ack_i,
  input  logic              mem_stall_i
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..256");
  end

  state_e           state_q, state_d;
  grant_e           gnt_q, gnt_d, gnt_pick;
  mem_req_t         req_q, req_d;
  logic             last_cram_q, last_cram_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             abandon_q, abandon_d;
  logic             mem_cyc_q, mem_cyc_d, mem_stb_q, mem_stb_d;
  logic [2:0]       ack_q, ack_d, err_q, err_d, stall_q, stall_d;
  logic [DW-1:0]    rom_dat_q, rom_dat_d, cram_dat_q, cram_dat_d, sav_dat_q, sav_dat_d;
  logic [2:0]       gnt_oh_c;
  logic             granted_stb_c, keep_c, mem_done_c, timeout_c;

  gbc_arb_pick u_pick (
    .rom_stb_i   (rom_stb_i),
    .cram_stb_i  (cram_stb_i),
    .sav_stb_i   (sav_stb_i),
    .last_cram_i (last_cram_q),
    .age_i       (age_q),
    .gnt_c_o     (gnt_pick)
  );

  assign gnt_oh_c      = gnt_onehot(gnt_q);
  assign granted_stb_c = |(gnt_oh_c & {sav_stb_i, cram_stb_i, rom_stb_i});
  // A requester that lets go of STB mid-cycle forfeits the response.
  assign keep_c        = granted_stb_c && !abandon_q;
  assign mem_done_c    = ((state_q == ST_ISSUE) && !mem_stall_i && mem_ack_i) ||
                         ((state_q == ST_WAIT) && mem_ack_i);

`ifdef GBC_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || state_q != ST_WAIT) tmo_cnt_q <= '0;
    else                                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end

  assign timeout_c = (state_q == ST_WAIT) && !mem_ack_i && (tmo_cnt_q == TMO_LAST);
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_pick != GNT_NONE) state_d = ST_ISSUE;
      ST_ISSUE: if (!mem_stall_i) state_d = mem_ack_i ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (mem_ack_i || timeout_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    req_d       = req_q;
    last_cram_d = last_cram_q;
    age_d       = age_q;
    abandon_d   = abandon_q;
    ack_d       = '0;
    err_d       = '0;
    rom_dat_d   = rom_dat_q;
    cram_dat_d  = cram_dat_q;
    sav_dat_d   = sav_dat_q;
    if (state_q == ST_IDLE) begin
      if (gnt_pick != GNT_NONE) begin
        gnt_d     = gnt_pick;
        abandon_d = 1'b0;
        case (gnt_pick)
          GNT_ROM: begin
            req_d       = '{addr: {1'b0, rom_addr_i}, we: 1'b0, dat: '0};
            last_cram_d = 1'b0;
          end
          GNT_CRAM: begin
            req_d       = '{addr: CRAM_BASE | MEM_AW'(cram_addr_i), we: cram_we_i, dat: cram_dat_i};
            last_cram_d = 1'b1;
          end
          default: req_d = '{addr: CRAM_BASE | MEM_AW'(sav_addr_i), we: sav_we_i, dat: sav_dat_i};
        endcase
        if (gnt_pick == GNT_SAV)                  age_d = '0;
        else if (sav_stb_i && age_q != AGE_MAX)   age_d = age_q + AGE_W'(1);
      end
    end else begin
      if (!granted_stb_c) abandon_d = 1'b1;
      if (mem_done_c && keep_c) begin
        ack_d = gnt_oh_c;
        case (gnt_q)
          GNT_ROM:  rom_dat_d  = mem_dat_i;
          GNT_CRAM: cram_dat_d = mem_dat_i;
          default:  sav_dat_d  = mem_dat_i;
        endcase
      end
      if (timeout_c && keep_c) err_d = gnt_oh_c;
      if (state_d == ST_IDLE) gnt_d = GNT_NONE;
    end
    mem_cyc_d = (state_d != ST_IDLE);
    mem_stb_d = (state_d == ST_ISSUE);
    stall_d   = (state_d == ST_ISSUE) ? ~gnt_onehot(gnt_d) : 3'b111;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      gnt_q       <= GNT_NONE;
      req_q       <= '0;
      last_cram_q <= 1'b1;
      age_q       <= '0;
      abandon_q   <= 1'b0;
      mem_cyc_q   <= 1'b0;
      mem_stb_q   <= 1'b0;
      ack_q       <= '0;
      err_q       <= '0;
      stall_q     <= '0;
      rom_dat_q   <= '0;
      cram_dat_q  <= '0;
      sav_dat_q   <= '0;
    end else begin
      gnt_q       <= gnt_d;
      req_q       <= req_d;
      last_cram_q <= last_cram_d;
      age_q       <= age_d;
      abandon_q   <= abandon_d;
      mem_cyc_q   <= mem_cyc_d;
      mem_stb_q   <= mem_stb_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
      rom_dat_q   <= rom_dat_d;
      cram_dat_q  <= cram_dat_d;
      sav_dat_q   <= sav_dat_d;
    end
  end

  assign rom_dat_o    = rom_dat_q;
  assign cram_dat_o   = cram_dat_q;
  assign sav_dat_o    = sav_dat_q;
  assign rom_ack_o    = ack_q[0];
  assign cram_ack_o   = ack_q[1];
  assign sav_ack_o    = ack_q[2];
  assign rom_err_o    = err_q[0];
  assign cram_err_o   = err_q[1];
  assign sav_err_o    = err_q[2];
  assign rom_stall_o  = stall_q[0];
  assign cram_stall_o = stall_q[1];
  assign sav_stall_o  = stall_q[2];
  assign mem_cyc_o    = mem_cyc_q;
  assign mem_stb_o    = mem_stb_q;
  assign mem_we_o     = req_q.we;
  assign mem_addr_o   = req_q.addr;
  assign mem_dat_o    = req_q.dat;

endmodule

// File: tb/tb_gbc_cart_mem_arbiter.sv
// Scoreboard bench for gbc_cart_mem_arbiter: a behavioural pipelined memory
// plus expected memory-side and requester-side queues.
module tb_gbc_cart_mem_arbiter;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rom_stb = 1'b0, cram_stb = 1'b0, sav_stb = 1'b0;
  logic        cram_we = 1'b0, sav_we = 1'b0;
  logic [22:0] rom_addr = '0;
  logic [16:0] cram_addr = '0, sav_addr = '0;
  logic [7:0]  cram_wdat = '0, sav_wdat = '0;
  logic [7:0]  rom_dat, cram_dat, sav_dat;
  logic        rom_ack, cram_ack, sav_ack, rom_err, cram_err, sav_err;
  logic        rom_stall, cram_stall, sav_stall;
  logic        mem_cyc, mem_stb, mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdat;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0, mem_stall = 1'b0;

  typedef struct { logic [23:0] addr; logic we; logic [7:0] dat; } mem_exp_t;
  typedef struct { logic [2:0] oh; logic [7:0] dat; } rsp_exp_t;
  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp[$];

  int errors = 0, checks = 0;
  int stall_cfg = 0, ack_delay = 1, stall_run = 0, pend_cnt = 0, stalled_total = 0;
  bit ack_en = 1'b1, err_ok = 1'b0;
  logic [23:0] acc_addr = '0;

  gbc_cart_mem_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rom_stb_i(rom_stb), .cram_stb_i(cram_stb), .sav_stb_i(sav_stb),
    .cram_we_i(cram_we), .sav_we_i(sav_we),
    .rom_addr_i(rom_addr), .cram_addr_i(cram_addr), .sav_addr_i(sav_addr),
    .cram_dat_i(cram_wdat), .sav_dat_i(sav_wdat),
    .rom_dat_o(rom_dat), .cram_dat_o(cram_dat), .sav_dat_o(sav_dat),
    .rom_ack_o(rom_ack), .cram_ack_o(cram_ack), .sav_ack_o(sav_ack),
    .rom_err_o(rom_err), .cram_err_o(cram_err), .sav_err_o(sav_err),
    .rom_stall_o(rom_stall), .cram_stall_o(cram_stall), .sav_stall_o(sav_stall),
    .mem_cyc_o(mem_cyc), .mem_stb_o(mem_stb), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_dat_o(mem_wdat), .mem_dat_i(mem_rdata),
    .mem_ack_i(mem_ack), .mem_stall_i(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] data_fn(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC3;
  endfunction

  task automatic push_rom(input logic [22:0] a, input bit want_ack);
    mem_exp_t m;
    rsp_exp_t r;
    m.addr = {1'b0, a}; m.we = 1'b0; m.dat = '0;
    exp_mem.push_back(m);
    if (want_ack) begin
      r.oh = 3'b001; r.dat = data_fn(m.addr);
      exp_rsp.push_back(r);
    end
  endtask

  task automatic push_ram(input bit sav, input logic [16:0] a, input bit we,
                          input logic [7:0] d, input bit want_ack);
    mem_exp_t m;
    rsp_exp_t r;
    m.addr = 24'h800000 | {7'd0, a}; m.we = we; m.dat = d;
    exp_mem.push_back(m);
    if (want_ack) begin
      r.oh = sav ? 3'b100 : 3'b010; r.dat = data_fn(m.addr);
      exp_rsp.push_back(r);
    end
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int seen;
    int cyc;
    seen = 0; cyc = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      seen += int'(rom_ack) + int'(cram_ack) + int'(sav_ack);
    end
    chk(tag, seen, n);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pipelined memory: stalls stall_cfg cycles, acks ack_delay cycles after accept.
  always @(negedge clk) begin
    mem_exp_t e;
    mem_ack = 1'b0;
    if (!mem_cyc) begin
      pend_cnt = 0; stall_run = 0; mem_stall = 1'b0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0 && ack_en) begin
          mem_ack = 1'b1; mem_rdata = data_fn(acc_addr);
        end
      end
      if (mem_stb) begin
        if (stall_run < stall_cfg) begin
          mem_stall = 1'b1; stall_run++; stalled_total++;
          if (exp_mem.size() > 0) chk("stall_addr", mem_addr, exp_mem[0].addr);
        end else begin
          mem_stall = 1'b0; stall_run = 0; pend_cnt = ack_delay; acc_addr = mem_addr;
          if (exp_mem.size() == 0) chk("mem_unexp", mem_stb, 0);
          else begin
            e = exp_mem.pop_front();
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_we", mem_we, e.we);
            if (e.we) chk("mem_wdat", mem_wdat, e.dat);
          end
        end
      end else mem_stall = 1'b0;
    end
  end

  // Requester-side monitor: every ACK pops the response scoreboard.
  always @(negedge clk) begin
    logic [2:0] acks;
    rsp_exp_t r;
    logic [7:0] d;
    acks = {sav_ack, cram_ack, rom_ack};
    if (rst_n && acks != 3'b000) begin
      chk("ack_cyc_low", mem_cyc, 0);
      if (exp_rsp.size() == 0) chk("ack_unexp", acks, 0);
      else begin
        r = exp_rsp.pop_front();
        chk("ack_port", acks, r.oh);
        case (r.oh)
          3'b001:  d = rom_dat;
          3'b010:  d = cram_dat;
          default: d = sav_dat;
        endcase
        chk("ack_data", d, r.dat);
      end
    end
    if (rst_n && !err_ok) chk("err_unexp", {sav_err, cram_err, rom_err}, 0);
  end

  initial begin
    int n;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cyc", mem_cyc, 0);
    chk("rst_stb", mem_stb, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_stall", {sav_stall, cram_stall, rom_stall}, 0);
    chk("rst_ack", {sav_ack, cram_ack, rom_ack}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stall", {sav_stall, cram_stall, rom_stall}, 3'b111);

    // single ROM read, zero-wait memory: ACK three cycles after STB
    push_rom(23'h004150, 1'b1);
    rom_addr = 23'h004150; rom_stb = 1'b1;
    @(negedge clk);
    chk("c1_cyc", mem_cyc, 1);
    chk("c1_stb", mem_stb, 1);
    chk("c1_addr", mem_addr, 24'h004150);
    chk("c1_stall", {sav_stall, cram_stall, rom_stall}, 3'b110);
    chk("c1_ack", rom_ack, 0);
    @(negedge clk);
    chk("c2_stb", mem_stb, 0);
    chk("c2_cyc", mem_cyc, 1);
    chk("c2_ack", rom_ack, 0);
    @(negedge clk);
    chk("c3_ack", rom_ack, 1);
    rom_stb = 1'b0;
    @(negedge clk);

    // CRAM write at a high address
    push_ram(1'b0, 17'h01FFF, 1'b1, 8'h5A, 1'b1);
    cram_addr = 17'h01FFF; cram_wdat = 8'h5A; cram_we = 1'b1; cram_stb = 1'b1;
    wait_acks(1, 20, "cram_wr_done");
    cram_stb = 1'b0; cram_we = 1'b0;
    @(negedge clk);

    // SAV read, top of the 17-bit range
    push_ram(1'b1, 17'h1FFFF, 1'b0, 8'h00, 1'b1);
    sav_addr = 17'h1FFFF; sav_stb = 1'b1;
    wait_acks(1, 20, "sav_rd_done");
    sav_stb = 1'b0;
    @(negedge clk);

    // memory stalls 5 cycles; top ROM address
    stall_cfg = 5; n = stalled_total;
    push_rom(23'h7FFFFF, 1'b1);
    rom_addr = 23'h7FFFFF; rom_stb = 1'b1;
    wait_acks(1, 30, "stall_done");
    rom_stb = 1'b0; stall_cfg = 0;
    chk("stall_cycles", stalled_total - n, 5);
    @(negedge clk);

    // ROM + CRAM held: strict alternation starting with ROM
    reset_dut();
    rom_addr = 23'h000100; cram_addr = 17'h00200;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_rom(23'h000100, 1'b1);
      else            push_ram(1'b0, 17'h00200, 1'b0, 8'h00, 1'b1);
    end
    rom_stb = 1'b1; cram_stb = 1'b1;
    wait_acks(4, 60, "alt_done");
    rom_stb = 1'b0; cram_stb = 1'b0;
    @(negedge clk);

    // all three held: SAV every 4th grant, aging restarts after it
    reset_dut();
    sav_addr = 17'h00033;
    begin
      int order[8];
      order = '{0, 1, 0, 2, 1, 0, 1, 2};
      foreach (order[i]) begin
        case (order[i])
          0:       push_rom(23'h000100, 1'b1);
          1:       push_ram(1'b0, 17'h00200, 1'b0, 8'h00, 1'b1);
          default: push_ram(1'b1, 17'h00033, 1'b0, 8'h00, 1'b1);
        endcase
      end
    end
    rom_stb = 1'b1; cram_stb = 1'b1; sav_stb = 1'b1;
    wait_acks(8, 120, "age_done");
    rom_stb = 1'b0; cram_stb = 1'b0; sav_stb = 1'b0;
    @(negedge clk);

    // requester abandons in WAIT: cycle completes, no ACK
    ack_delay = 4;
    push_ram(1'b0, 17'h00777, 1'b0, 8'h00, 1'b0);
    cram_addr = 17'h00777; cram_stb = 1'b1;
    repeat (2) @(negedge clk);
    cram_stb = 1'b0;
    n = 0;
    while (mem_cyc && n < 20) begin @(negedge clk); n++; end
    chk("abandon_cyc_end", mem_cyc, 0);
    repeat (3) @(negedge clk);
    chk("abandon_mem_q", exp_mem.size(), 0);
    ack_delay = 1;

    // reset while in WAIT
    ack_en = 1'b0;
    push_rom(23'h000ABC, 1'b0);
    rom_addr = 23'h000ABC; rom_stb = 1'b1;
    repeat (2) @(negedge clk);
    chk("wait_cyc", mem_cyc, 1);
    chk("wait_stb", mem_stb, 0);
    rst_n = 1'b0; rom_stb = 1'b0;
    @(negedge clk);
    chk("rstw_cyc", mem_cyc, 0);
    chk("rstw_ack", rom_ack, 0);
    chk("rstw_err", rom_err, 0);
    rst_n = 1'b1; ack_en = 1'b1;
    repeat (2) @(negedge clk);

`ifdef GBC_ARB_TIMEOUT_EN
    // watchdog: no ACK ever
    ack_en = 1'b0; err_ok = 1'b1;
    push_rom(23'h000055, 1'b0);
    rom_addr = 23'h000055; rom_stb = 1'b1;
    n = 0;
    for (int c = 0; c < 400 && !rom_err; c++) begin
      @(negedge clk);
      if (mem_cyc && !mem_stb) n++;
    end
    chk("tmo_err", rom_err, 1);
    chk("tmo_wait_cycles", n, 255);
    chk("tmo_cyc_drop", mem_cyc, 0);
    rom_stb = 1'b0;
    @(negedge clk);
    err_ok = 1'b0; ack_en = 1'b1;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("rsp_q_empty", exp_rsp.size(), 0);
    chk("mem_q_empty", exp_mem.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
